// File: rtl/natalius_pkg.sv
// Shared definitions for the Natalius core control path.
// Holds the opcode map, the ALU operation codes the control unit
// drives onto opalu, and the control FSM state encoding.
package natalius_pkg;

  // Opcodes, IR[15:11]
  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_LDI   = 5'b00001;
  localparam logic [4:0] OP_LDM   = 5'b00010;
  localparam logic [4:0] OP_STM   = 5'b00011;
  localparam logic [4:0] OP_JMP   = 5'b00100;
  localparam logic [4:0] OP_JZ    = 5'b00101;
  localparam logic [4:0] OP_JNZ   = 5'b00110;
  localparam logic [4:0] OP_JC    = 5'b00111;
  localparam logic [4:0] OP_JNC   = 5'b01000;
  localparam logic [4:0] OP_CALL  = 5'b01001;
  localparam logic [4:0] OP_RET   = 5'b01010;
  localparam logic [4:0] OP_SHIFT = 5'b01011;
  localparam logic [4:0] OP_ADDI  = 5'b01100;
  localparam logic [4:0] OP_CMP   = 5'b01101;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  // ALU operation codes; register-register ALU opcodes 10xxx pass
  // op[2:0] straight through, so these sit in the same code space.
  localparam logic [2:0] ALU_PASSA = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b101;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the control unit and the data path.
//   i_instruction  program word (synchronous memory, valid one cycle after address)
//   i_z, i_c       registered flags
//   i_stack_addr   return address from the LIFO
//   o_*            data-path controls, I/O port strobes/address and halted
// master: control unit side; slave: data path side.
interface control_unit_if;
  logic [15:0] i_instruction;
  logic        i_z;
  logic        i_c;
  logic [10:0] i_stack_addr;

  logic        o_insel;
  logic        o_we;
  logic [2:0]  o_raa;
  logic [2:0]  o_rab;
  logic [2:0]  o_wa;
  logic [2:0]  o_opalu;
  logic [2:0]  o_sh;
  logic        o_selpc;
  logic        o_selk;
  logic        o_ldpc;
  logic        o_ldflag;
  logic        o_wr_en;
  logic        o_rd_en;
  logic [10:0] o_ninst_addr;
  logic [7:0]  o_kte;
  logic [7:0]  o_imm;
  logic        o_selimm;
  logic        o_rd_strobe;
  logic        o_wr_strobe;
  logic [7:0]  o_port_addr;
  logic        o_halted;

  modport master (
    input  i_instruction, i_z, i_c, i_stack_addr,
    output o_insel, o_we, o_raa, o_rab, o_wa, o_opalu, o_sh, o_selpc,
           o_selk, o_ldpc, o_ldflag, o_wr_en, o_rd_en, o_ninst_addr,
           o_kte, o_imm, o_selimm, o_rd_strobe, o_wr_strobe, o_port_addr,
           o_halted
  );

  modport slave (
    output i_instruction, i_z, i_c, i_stack_addr,
    input  o_insel, o_we, o_raa, o_rab, o_wa, o_opalu, o_sh, o_selpc,
           o_selk, o_ldpc, o_ldflag, o_wr_en, o_rd_en, o_ninst_addr,
           o_kte, o_imm, o_selimm, o_rd_strobe, o_wr_strobe, o_port_addr,
           o_halted
  );
endinterface

// File: rtl/control_unit.sv
// Natalius control unit: three-cycle fetch/decode/execute sequencer.
// Ports:
//   clk   clock
//   rst   asynchronous, active-high reset
//   bus   control_unit_if.master (instruction/flags/stack in, controls out)
// All controls are combinational from state and IR, so an asserted rst
// drops them on the spot even in the middle of EXEC.
//
// state    | meaning
// ---------+------------------------------------------------------
// S_FETCH  | PC on the memory address; waiting for the word
// S_DECODE | memory word valid; latched into IR at end of cycle
// S_EXEC   | controls decoded from IR asserted for this cycle only
// S_HALT   | core stopped; only rst leaves this state
module control_unit
  import natalius_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  control_unit_if.master bus
);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_ir;

  logic [4:0]  w_op;
  logic [2:0]  w_rd;
  logic [2:0]  w_ra;
  logic [2:0]  w_rb;
  logic [7:0]  w_k;
  logic [10:0] w_addr;

  assign w_op   = r_ir[15:11];
  assign w_rd   = r_ir[10:8];
  assign w_ra   = r_ir[7:5];
  assign w_rb   = r_ir[4:2];
  assign w_k    = r_ir[7:0];
  assign w_addr = r_ir[10:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) r_ir <= bus.i_instruction;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    bus.o_insel      = 1'b0;
    bus.o_we         = 1'b0;
    bus.o_raa        = 3'd0;
    bus.o_rab        = 3'd0;
    bus.o_wa         = 3'd0;
    bus.o_opalu      = 3'd0;
    bus.o_sh         = 3'd0;
    bus.o_selpc      = 1'b0;
    bus.o_selk       = 1'b0;
    bus.o_ldpc       = 1'b0;
    bus.o_ldflag     = 1'b0;
    bus.o_wr_en      = 1'b0;
    bus.o_rd_en      = 1'b0;
    bus.o_ninst_addr = 11'd0;
    bus.o_kte        = 8'd0;
    bus.o_imm        = 8'd0;
    bus.o_selimm     = 1'b0;
    bus.o_rd_strobe  = 1'b0;
    bus.o_wr_strobe  = 1'b0;
    bus.o_port_addr  = 8'd0;
    bus.o_halted     = (r_state == S_HALT);

    case (r_state)
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC: begin
        w_next_state = (w_op == OP_HALT) ? S_HALT : S_FETCH;
        bus.o_ldpc   = 1'b1;
        case (w_op) inside
          OP_LDI: begin
            bus.o_we   = 1'b1;
            bus.o_wa   = w_rd;
            bus.o_selk = 1'b1;
            bus.o_kte  = w_k;
          end
          OP_LDM: begin
            bus.o_rd_strobe = 1'b1;
            bus.o_port_addr = w_k;
            bus.o_we        = 1'b1;
            bus.o_wa        = w_rd;
          end
          OP_STM: begin
            bus.o_wr_strobe = 1'b1;
            bus.o_port_addr = w_k;
            bus.o_raa       = w_rd;
            bus.o_opalu     = ALU_PASSA;
          end
          OP_JMP: begin
            bus.o_selpc      = 1'b1;
            bus.o_ninst_addr = w_addr;
          end
          OP_JZ, OP_JNZ, OP_JC, OP_JNC: begin
            // Flags are sampled live during EXEC; they are registered upstream.
            if ((w_op == OP_JZ  &&  bus.i_z) || (w_op == OP_JNZ && !bus.i_z) ||
                (w_op == OP_JC  &&  bus.i_c) || (w_op == OP_JNC && !bus.i_c)) begin
              bus.o_selpc      = 1'b1;
              bus.o_ninst_addr = w_addr;
            end
          end
          OP_CALL: begin
            bus.o_wr_en      = 1'b1;
            bus.o_selpc      = 1'b1;
            bus.o_ninst_addr = w_addr;
          end
          OP_RET: begin
            bus.o_rd_en      = 1'b1;
            bus.o_selpc      = 1'b1;
            bus.o_ninst_addr = bus.i_stack_addr;
          end
          OP_SHIFT: begin
            bus.o_raa   = w_ra;
            bus.o_opalu = ALU_PASSA;
            bus.o_sh    = w_rb;
            bus.o_insel = 1'b1;
            bus.o_we    = 1'b1;
            bus.o_wa    = w_rd;
          end
          OP_ADDI: begin
            bus.o_raa    = w_rd;
            bus.o_wa     = w_rd;
            bus.o_selimm = 1'b1;
            bus.o_imm    = w_k;
            bus.o_opalu  = ALU_ADD;
            bus.o_insel  = 1'b1;
            bus.o_we     = 1'b1;
            bus.o_ldflag = 1'b1;
          end
          OP_CMP: begin
            bus.o_raa    = w_ra;
            bus.o_rab    = w_rb;
            bus.o_opalu  = ALU_SUB;
            bus.o_ldflag = 1'b1;
          end
          OP_HALT: bus.o_ldpc = 1'b0;
          5'b10???: begin
            bus.o_opalu  = w_op[2:0];
            bus.o_raa    = w_ra;
            bus.o_rab    = w_rb;
            bus.o_wa     = w_rd;
            bus.o_insel  = 1'b1;
            bus.o_we     = 1'b1;
            bus.o_ldflag = 1'b1;
          end
          default: ;  // NOP and unassigned opcodes: PC+1 only
        endcase
      end
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
  import natalius_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  control_unit_if bus();

  control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Packed view of every output, same field order as the model.
  logic [61:0] act_vec;
  assign act_vec = {bus.o_halted, bus.o_insel, bus.o_we, bus.o_raa, bus.o_rab,
                    bus.o_wa, bus.o_opalu, bus.o_sh, bus.o_selpc, bus.o_selk,
                    bus.o_ldpc, bus.o_ldflag, bus.o_wr_en, bus.o_rd_en,
                    bus.o_ninst_addr, bus.o_kte, bus.o_imm, bus.o_selimm,
                    bus.o_rd_strobe, bus.o_wr_strobe, bus.o_port_addr};

  // Reference model: position within the 3-cycle instruction slot.
  // 0 fetch, 1 decode, 2 execute, 3 stopped.
  int          m_phase = 0;
  logic [15:0] m_ir    = 16'h0000;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_ir    <= 16'h0000;
    end else begin
      case (m_phase)
        0: m_phase <= 1;
        1: begin m_ir <= bus.i_instruction; m_phase <= 2; end
        2: m_phase <= (m_ir[15:11] == 5'd31) ? 3 : 0;
        default: m_phase <= 3;
      endcase
    end
  end

  function automatic logic [61:0] model(int ph, logic [15:0] ir, logic z, logic c,
                                        logic [10:0] sa);
    logic halted, insel, we, selpc, selk, ldpc, ldflag, wr_en, rd_en, selimm, rds, wrs;
    logic [2:0] raa, rab, wa, opalu, sh;
    logic [10:0] nia;
    logic [7:0] kte, imm, pa;
    int op;
    logic taken;
    {halted, insel, we, selpc, selk, ldpc, ldflag, wr_en, rd_en, selimm, rds, wrs} = '0;
    {raa, rab, wa, opalu, sh} = '0;
    nia = '0; kte = '0; imm = '0; pa = '0;
    op = int'(ir[15:11]);
    halted = (ph == 3);
    if (ph == 2) begin
      ldpc = (op != 31);
      if (op == 1) begin we = 1; wa = ir[10:8]; selk = 1; kte = ir[7:0]; end
      else if (op == 2) begin rds = 1; pa = ir[7:0]; we = 1; wa = ir[10:8]; end
      else if (op == 3) begin wrs = 1; pa = ir[7:0]; raa = ir[10:8]; opalu = ALU_PASSA; end
      else if (op == 4) begin selpc = 1; nia = ir[10:0]; end
      else if (op >= 5 && op <= 8) begin
        taken = (op == 5) ? z : (op == 6) ? !z : (op == 7) ? c : !c;
        if (taken) begin selpc = 1; nia = ir[10:0]; end
      end
      else if (op == 9)  begin wr_en = 1; selpc = 1; nia = ir[10:0]; end
      else if (op == 10) begin rd_en = 1; selpc = 1; nia = sa; end
      else if (op == 11) begin raa = ir[7:5]; opalu = ALU_PASSA; sh = ir[4:2];
                               insel = 1; we = 1; wa = ir[10:8]; end
      else if (op == 12) begin raa = ir[10:8]; wa = ir[10:8]; selimm = 1; imm = ir[7:0];
                               opalu = ALU_ADD; insel = 1; we = 1; ldflag = 1; end
      else if (op == 13) begin raa = ir[7:5]; rab = ir[4:2]; opalu = ALU_SUB; ldflag = 1; end
      else if (op >= 16 && op <= 23) begin
        opalu = ir[13:11]; raa = ir[7:5]; rab = ir[4:2]; wa = ir[10:8];
        insel = 1; we = 1; ldflag = 1;
      end
    end
    return {halted, insel, we, raa, rab, wa, opalu, sh, selpc, selk, ldpc, ldflag,
            wr_en, rd_en, nia, kte, imm, selimm, rds, wrs, pa};
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [61:0] exp_vec;
    if (!rst) begin
      exp_vec = model(m_phase, m_ir, bus.i_z, bus.i_c, bus.i_stack_addr);
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL outputs t=%0t phase=%0d ir=%h got=%h expected=%h",
                 $time, m_phase, m_ir, act_vec, exp_vec);
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Called with the DUT in FETCH just after a clock edge; returns in EXEC.
  task automatic to_exec(logic [15:0] w, logic zv, logic cv, logic [10:0] sa);
    bus.i_instruction = w;
    bus.i_z = zv;
    bus.i_c = cv;
    bus.i_stack_addr = sa;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic leave_exec();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] w;
    logic z, c;
    logic [10:0] sa;
  } vec_t;

  vec_t vecs[] = '{
    '{16'h1281, 1'b0, 1'b0, 11'h000},  // LDM r2,0x81
    '{16'h1C33, 1'b0, 1'b0, 11'h000},  // STM r4,0x33
    '{16'h27FF, 1'b0, 1'b0, 11'h000},  // JMP 0x7FF
    '{16'h3155, 1'b0, 1'b0, 11'h000},  // JNZ taken
    '{16'h3155, 1'b1, 1'b0, 11'h000},  // JNZ not taken
    '{16'h3A0F, 1'b0, 1'b1, 11'h000},  // JC taken
    '{16'h3A0F, 1'b1, 1'b0, 11'h000},  // JC not taken
    '{16'h4444, 1'b0, 1'b0, 11'h000},  // JNC taken
    '{16'h4444, 1'b0, 1'b1, 11'h000},  // JNC not taken
    '{16'h5B2C, 1'b0, 1'b0, 11'h000},  // SHIFT
    '{16'h6455, 1'b1, 1'b1, 11'h000},  // ADDI r4,0x55
    '{16'h6944, 1'b0, 1'b0, 11'h000},  // CMP
    '{16'h7000, 1'b1, 1'b1, 11'h3FF},  // undefined opcode
    '{16'hBFFC, 1'b0, 1'b0, 11'h000},  // ALU op 111
    '{16'h0000, 1'b0, 1'b0, 11'h000}   // NOP
  };

  initial begin
    bus.i_instruction = 16'h0000;
    bus.i_z = 1'b0;
    bus.i_c = 1'b0;
    bus.i_stack_addr = 11'h000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {2'b00, act_vec[61:32]}, 32'h0);
    check("reset_outputs_lo", act_vec[31:0], 32'h0);
    rst = 1'b0;

    // LDI r3,0x5A
    to_exec(16'h0B5A, 1'b0, 1'b0, 11'h000);
    check("ldi_we", bus.o_we, 1);
    check("ldi_wa", bus.o_wa, 3);
    check("ldi_selk", bus.o_selk, 1);
    check("ldi_insel", bus.o_insel, 0);
    check("ldi_kte", bus.o_kte, 32'h5A);
    check("ldi_ldpc", bus.o_ldpc, 1);
    check("ldi_selpc", bus.o_selpc, 0);
    leave_exec();
    check("after_exec_we", bus.o_we, 0);

    // JZ 0x123
    to_exec(16'h2923, 1'b1, 1'b0, 11'h000);
    check("jz_taken_selpc", bus.o_selpc, 1);
    check("jz_taken_addr", bus.o_ninst_addr, 32'h123);
    leave_exec();
    to_exec(16'h2923, 1'b0, 1'b0, 11'h000);
    check("jz_not_taken_selpc", bus.o_selpc, 0);
    leave_exec();

    // CALL 0x040 then RET
    to_exec(16'h4840, 1'b0, 1'b0, 11'h000);
    check("call_wr_en", bus.o_wr_en, 1);
    check("call_addr", bus.o_ninst_addr, 32'h040);
    leave_exec();
    to_exec(16'h5000, 1'b0, 1'b0, 11'h011);
    check("ret_rd_en", bus.o_rd_en, 1);
    check("ret_addr", bus.o_ninst_addr, 32'h011);
    check("ret_selpc", bus.o_selpc, 1);
    leave_exec();

    // ALU op 001 r2 <- r1, r0
    to_exec(16'h8A20, 1'b0, 1'b0, 11'h000);
    check("alu_wa", bus.o_wa, 2);
    check("alu_raa", bus.o_raa, 1);
    check("alu_rab", bus.o_rab, 0);
    check("alu_opalu", bus.o_opalu, 1);
    check("alu_insel", bus.o_insel, 1);
    check("alu_we", bus.o_we, 1);
    check("alu_ldflag", bus.o_ldflag, 1);
    leave_exec();

    foreach (vecs[i]) begin
      to_exec(vecs[i].w, vecs[i].z, vecs[i].c, vecs[i].sa);
      leave_exec();
    end

    // Reset asserted in the middle of EXEC
    to_exec(16'h0B5A, 1'b0, 1'b0, 11'h000);
    rst = 1'b1;
    #1;
    check("midexec_rst_we", bus.o_we, 0);
    check("midexec_rst_ldpc", bus.o_ldpc, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    to_exec(16'h0B5A, 1'b0, 1'b0, 11'h000);
    check("post_rst_ldi_we", bus.o_we, 1);
    leave_exec();

    // HALT
    to_exec(16'hF800, 1'b0, 1'b0, 11'h000);
    check("halt_exec_ldpc", bus.o_ldpc, 0);
    leave_exec();
    for (int i = 0; i < 20; i++) begin
      bus.i_instruction = 16'h0B5A;
      check("halted_flag", bus.o_halted, 1);
      check("halted_ldpc", bus.o_ldpc, 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("rst_clears_halted", bus.o_halted, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    to_exec(16'h6455, 1'b0, 1'b0, 11'h000);
    check("after_halt_addi_imm", bus.o_imm, 32'h55);
    leave_exec();
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports: clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-002 instruction in 16: program word at inst_addr, valid one cycle after address, synchronous memory.
REQ-003 z, c in 1: registered flags from the data path.
REQ-004 stack_addr in 11: return address from the LIFO, valid combinationally.
REQ-005 data-path controls, all out: insel 1, we 1, raa 3, rab 3, wa 3, opalu 3, sh 3, selpc 1, selk 1, ldpc 1, ldflag 1, wr_en 1, rd_en 1, ninst_addr 11, kte 8, imm 8, selimm 1.
REQ-006 rd_strobe out 1, wr_strobe out 1, port_addr out 8: I/O port read/write strobes and address.
REQ-007 halted out 1: core stopped.

Function
REQ-008 FSM states FETCH -> DECODE -> EXEC -> FETCH; every instruction takes 3 cycles.
REQ-009 FETCH: wait for memory; DECODE: latch instruction into 16-bit IR; EXEC: assert controls decoded from IR for exactly one cycle.
REQ-010 Fields: op=IR[15:11], rd=IR[10:8], ra=IR[7:5], rb=IR[4:2], k=IR[7:0], addr=IR[10:0].
REQ-011 Outside EXEC, every output except halted SHALL be 0.
REQ-012 EXEC SHALL assert ldpc=1 for every opcode except HALT; selpc=0 (PC+1) unless stated below.
REQ-013 00000 NOP: only ldpc.
REQ-014 00001 LDI: we=1, wa=rd, selk=1, insel=0, kte=k.
REQ-015 00010 LDM: rd_strobe=1, port_addr=k, we=1, wa=rd, selk=0, insel=0; data_in sampled at end of EXEC.
REQ-016 00011 STM: wr_strobe=1, port_addr=k, raa=IR[10:8], opalu=ALU_PASSA, sh=0.
REQ-017 00100 JMP: selpc=1, ninst_addr=addr.
REQ-018 00101 JZ / 00110 JNZ / 00111 JC / 01000 JNC: selpc=1, ninst_addr=addr only if z=1 / z=0 / c=1 / c=0 sampled during EXEC; else selpc=0.
REQ-019 01001 CALL: wr_en=1 (pushes current PC), selpc=1, ninst_addr=addr.
REQ-020 01010 RET: rd_en=1, selpc=1, ninst_addr=stack_addr.
REQ-021 01011 SHIFT: raa=ra, opalu=ALU_PASSA, sh=rb field IR[4:2], insel=1, we=1, wa=rd, ldflag=0.
REQ-022 01100 ADDI: raa=rd, wa=rd, selimm=1, imm=k, opalu=ALU_ADD, insel=1, we=1, ldflag=1.
REQ-023 01101 CMP: raa=ra, rab=rb, opalu=ALU_SUB, ldflag=1, we=0.
REQ-024 10xxx ALU: opalu=op[2:0], raa=ra, rab=rb, wa=rd, insel=1, we=1, ldflag=1, selimm=0, sh=0.
REQ-025 11111 HALT: enter HALT state, halted=1, ldpc=0; remains until rst.
REQ-026 All other opcodes SHALL execute as NOP.
REQ-027 Stack overflow/underflow SHALL NOT be checked; LIFO behaviour governs.

Reset
REQ-028 rst SHALL force state FETCH, IR=0x0000, halted=0, all outputs 0, effective immediately including mid-EXEC.
REQ-029 First fetch after rst release SHALL use PC=0 supplied by the data path.

Structure
REQ-030 Opcode constants, ALU_ADD/ALU_SUB/ALU_PASSA and state encoding SHALL reside in shared package natalius_pkg, values matching the ALU.
REQ-031 Single module; no sub-module required; outputs combinational from state and IR.

Verification
REQ-032 IR=0x0B5A (LDI r3,0x5A) -> EXEC: we=1, wa=3, selk=1, insel=0, kte=0x5A, ldpc=1, selpc=0.
REQ-033 IR=0x2923 (JZ 0x123): z=1 -> selpc=1, ninst_addr=0x123; z=0 -> selpc=0.
REQ-034 IR=0x4840 (CALL 0x040) -> wr_en=1, ninst_addr=0x040; then IR=0x5000 (RET), stack_addr=0x011 -> rd_en=1, ninst_addr=0x011, selpc=1.
REQ-035 IR=0x8A20 -> wa=2, raa=1, rab=0, opalu=3'b001, insel=1, we=1, ldflag=1.
REQ-036 rst pulsed during EXEC of LDI -> we=0 and ldpc=0 immediately; state FETCH after release.
REQ-037 IR=0xF800 (HALT) -> halted=1, ldpc=0 for 20 cycles; rst clears halted.
